// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory stream reader: default address and
// data widths, the reader state encoding, and the depth that a zero length
// stands for.
// Ports: none (package only).
package dmem_pkg;

   localparam int DMEM_ADDR_W = 8;
   localparam int DMEM_DATA_W = 8;

   // A programmed length of zero stands for one full sweep of the memory.
   localparam int DMEM_FULL_DEPTH = 1 << DMEM_ADDR_W;

   // ST_CSUM is only entered when DMEM_STREAM_CHECKSUM_EN is defined.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_CSUM   = 2'd3
   } dmem_state_e;

endpackage

// File: rtl/dmem_out_stage.sv
// dmem_out_stage
// Single holding register for the outgoing byte stream. A beat is loaded when
// the owner asserts load (only while free), and is consumed by a valid/ready
// handshake. While a beat waits for out_ready the data and last flag are held.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   load           capture load_data/load_last as a new beat
//   load_data      byte to present
//   load_last      final-beat flag for the byte
//   out_ready      downstream accept
//   out_data       stream byte
//   out_valid      stream beat valid
//   out_last       final-beat flag
//   free           register can take a new beat this cycle
module dmem_out_stage
   import dmem_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   output logic              free
);

   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;

   // The slot is free when empty or when its current beat leaves this cycle,
   // which lets a new beat replace the old one every cycle under full rate.
   assign free = !valid_q || out_ready;

   // A load wins over a plain consume; a consume with nothing new empties the
   // slot and drops the last flag so it never lingers on an idle stream.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (load) begin
         data_d  = load_data;
         valid_d = 1'b1;
         last_d  = load_last;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   // Holding register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;

endmodule

// File: rtl/dmem_stream_reader.sv
// dmem_stream_reader
// Sweeps a programmed address range of the data memory through its
// combinational read port and emits each byte on a valid/ready stream, with
// the final beat flagged by out_last.
// Optional feature: define DMEM_STREAM_CHECKSUM_EN to append one extra beat
// carrying the 8-bit running sum of the data bytes (that beat carries
// out_last instead of the final data beat).
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   start          transfer request, sampled only when idle
//   base_addr      first address, sampled with start
//   len            byte count, sampled with start (0 means full depth)
//   busy           transfer in progress
//   done           one-cycle pulse after the final beat is accepted
//   read_addr      registered address to the memory read port
//   read_data      memory read data for read_addr
//   out_data       stream byte
//   out_valid      stream beat valid
//   out_ready      downstream accept
//   out_last       final beat of the transfer
module dmem_stream_reader
   import dmem_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] read_addr,
   input  logic [DATA_W-1:0] read_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   // The remaining count needs one extra bit to hold the full depth.
   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(1) << ADDR_W;

   dmem_state_e       state_q, state_d;
   logic [ADDR_W-1:0] read_addr_q, read_addr_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   logic              done_q, done_d;

   logic              load;
   logic [DATA_W-1:0] load_data;
   logic              load_last;
   logic              stage_free;

`ifdef DMEM_STREAM_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
`endif

   // Next-state logic. Each data beat is taken straight from read_data when
   // the output slot is free, and the address advances in the same cycle, so
   // back-pressure simply freezes the address. The beat loaded with one byte
   // remaining is the final data beat.
   always_comb begin
      state_d     = state_q;
      read_addr_d = read_addr_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      load        = 1'b0;
      load_data   = read_data;
      load_last   = 1'b0;
`ifdef DMEM_STREAM_CHECKSUM_EN
      sum_d       = sum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               read_addr_d = base_addr;
               remaining_d = (len == '0) ? FULL_COUNT : {1'b0, len};
               state_d     = ST_STREAM;
`ifdef DMEM_STREAM_CHECKSUM_EN
               sum_d       = '0;
`endif
            end
         end
         ST_STREAM: begin
            if (stage_free) begin
               load        = 1'b1;
               read_addr_d = read_addr_q + ADDR_W'(1);
               remaining_d = remaining_q - (ADDR_W+1)'(1);
`ifdef DMEM_STREAM_CHECKSUM_EN
               sum_d       = sum_q + read_data;
               if (remaining_q == (ADDR_W+1)'(1)) begin
                  state_d = ST_CSUM;
               end
`else
               if (remaining_q == (ADDR_W+1)'(1)) begin
                  load_last = 1'b1;
                  state_d   = ST_DRAIN;
               end
`endif
            end
         end
`ifdef DMEM_STREAM_CHECKSUM_EN
         // The slot frees exactly when the last data beat is accepted, and by
         // then the sum already includes that byte.
         ST_CSUM: begin
            if (stage_free) begin
               load      = 1'b1;
               load_data = sum_q;
               load_last = 1'b1;
               state_d   = ST_DRAIN;
            end
         end
`endif
         ST_DRAIN: begin
            if (out_ready) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, address and count registers with synchronous reset; a reset in
   // the middle of a transfer drops it without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         read_addr_q <= '0;
         remaining_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         read_addr_q <= read_addr_d;
         remaining_q <= remaining_d;
         done_q      <= done_d;
      end
   end

`ifdef DMEM_STREAM_CHECKSUM_EN
   // Running checksum of the data bytes of the current transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end
`endif

   dmem_out_stage #(
      .DATA_W (DATA_W)
   ) u_out_stage (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data (load_data),
      .load_last (load_last),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .free      (stage_free)
   );

   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign read_addr = read_addr_q;

endmodule

// File: tb/tb_dmem_stream_reader.sv
// tb_dmem_stream_reader
// Self-checking bench for dmem_stream_reader. A 256-byte memory model drives
// read_data, and a reference model builds the expected beat list for each
// transfer directly from base, length and memory contents.
module tb_dmem_stream_reader;
   import dmem_pkg::*;

   localparam int FULL = DMEM_FULL_DEPTH;
`ifdef DMEM_STREAM_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] base_addr;
   logic [7:0] len;
   logic       busy;
   logic       done;
   logic [7:0] read_addr;
   logic [7:0] read_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   logic [7:0] mem [FULL];

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] got_data [$];
   logic       got_last [$];
   logic [7:0] exp_data [$];
   logic       exp_last [$];
   int         done_cnt, done_cyc, last_hs_cyc, first_valid_cyc, stab_viol, cyc;
   logic       timed_out, busy_at_start, busy_at_done;
   logic [7:0] addr_at_start, addr_at_done;

   // Combinational memory read port.
   assign read_data = mem[read_addr];

   // Free-running clock.
   always #5 clk = ~clk;

   dmem_stream_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .read_addr (read_addr),
      .read_data (read_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   // Reference model: the bytes at base..base+L-1 (mod depth), plus the
   // mod-256 sum when the checksum beat is enabled; only the final beat is last.
   function automatic void build_expected(input logic [7:0] b, input logic [7:0] l);
      int n;
      int sum;
      n   = (l == 8'd0) ? FULL : int'(l);
      sum = 0;
      exp_data.delete();
      exp_last.delete();
      for (int i = 0; i < n; i++) begin
         exp_data.push_back(mem[(int'(b) + i) % FULL]);
         exp_last.push_back(1'b0);
         sum = (sum + int'(mem[(int'(b) + i) % FULL])) % 256;
      end
      if (CSUM_EN) begin
         exp_data.push_back(8'(sum));
         exp_last.push_back(1'b0);
      end
      exp_last[exp_last.size()-1] = 1'b1;
   endfunction

   // Runs one transfer and records what the stream did. mode 0: ready high,
   // mode 1: random ready, mode 2: ready pattern 1,0,0 from the first beat.
   // Returns at the falling edge of the done cycle (or on timeout).
   task automatic drive_transfer(input logic [7:0] b, input logic [7:0] l, input int mode);
      logic       prev_valid, prev_ready, prev_last, finished;
      logic [7:0] prev_data;
      got_data.delete();
      got_last.delete();
      done_cnt = 0; done_cyc = -1; last_hs_cyc = -1; first_valid_cyc = -1;
      stab_viol = 0; timed_out = 1'b0; busy_at_done = 1'b1; addr_at_done = 8'h00;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0; prev_data = 8'h00;
      finished = 1'b0;
      start = 1'b1; base_addr = b; len = l; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; base_addr = 8'($urandom); len = 8'($urandom);
      busy_at_start = busy;
      addr_at_start = read_addr;
      cyc = 0;
      while (!finished && cyc < 3000) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (cyc % 3 == 1);
         endcase
         @(negedge clk);
         if (prev_valid && !prev_ready &&
             (!out_valid || out_data !== prev_data || out_last !== prev_last))
            stab_viol++;
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
            addr_at_done = read_addr;
            finished     = 1'b1;
         end
         if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
            last_hs_cyc = cyc;
         end
         prev_valid = out_valid; prev_ready = out_ready;
         prev_data  = out_data;  prev_last  = out_last;
         if (!finished) begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      if (!finished) timed_out = 1'b1;
   endtask

   // Reset values of every output.
   task automatic test_reset();
      rst = 1'b1; start = 1'b0; base_addr = 8'h00; len = 8'h00; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, out_valid, out_last} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL reset_flags: got %b, expected 0000", {busy, done, out_valid, out_last});
      end
      n_cmp++;
      if (read_addr !== 8'h00 || out_data !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL reset_data: got addr %0h data %0h, expected 0 0", read_addr, out_data);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Directed transfers over the identity memory: basic, wrap, full depth,
   // stalled, and the short range used for the checksum case.
   task automatic test_stream_cases();
      logic [7:0] c_base [5] = '{8'h10, 8'hFE, 8'h00, 8'h20, 8'h01};
      logic [7:0] c_len  [5] = '{8'd4,  8'd3,  8'd0,  8'd4,  8'd3};
      int         c_mode [5] = '{0, 0, 0, 2, 0};
      string      c_name [5] = '{"basic", "wrap", "full", "stall", "short"};
      int         n_bytes;
      for (int i = 0; i < FULL; i++) mem[i] = 8'(i);
      for (int c = 0; c < 5; c++) begin
         build_expected(c_base[c], c_len[c]);
         n_bytes = (c_len[c] == 8'd0) ? FULL : int'(c_len[c]);
         drive_transfer(c_base[c], c_len[c], c_mode[c]);
         n_cmp++;
         if (timed_out) begin
            n_fail++;
            $display("[TB] FAIL %s_timeout: got no done, expected done", c_name[c]);
         end
         n_cmp++;
         if (busy_at_start !== 1'b1 || addr_at_start !== c_base[c]) begin
            n_fail++;
            $display("[TB] FAIL %s_start: got busy %b addr %0h, expected 1 %0h",
                     c_name[c], busy_at_start, addr_at_start, c_base[c]);
         end
         n_cmp++;
         if (got_data.size() !== exp_data.size()) begin
            n_fail++;
            $display("[TB] FAIL %s_count: got %0d beats, expected %0d",
                     c_name[c], got_data.size(), exp_data.size());
         end
         for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
               n_fail++;
               $display("[TB] FAIL %s_beat%0d: got %0h last %b, expected %0h last %b",
                        c_name[c], i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
         end
         n_cmp++;
         if (stab_viol !== 0) begin
            n_fail++;
            $display("[TB] FAIL %s_stable: got %0d changes while stalled, expected 0", c_name[c], stab_viol);
         end
         n_cmp++;
         if (first_valid_cyc !== 1) begin
            n_fail++;
            $display("[TB] FAIL %s_latency: got first valid at %0d, expected 1", c_name[c], first_valid_cyc);
         end
         n_cmp++;
         if (done_cnt !== 1 || done_cyc !== last_hs_cyc + 1 || busy_at_done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s_done: got cyc %0d busy %b, expected cyc %0d busy 0",
                     c_name[c], done_cyc, busy_at_done, last_hs_cyc + 1);
         end
         n_cmp++;
         if (addr_at_done !== 8'((int'(c_base[c]) + n_bytes) % FULL)) begin
            n_fail++;
            $display("[TB] FAIL %s_end_addr: got %0h, expected %0h",
                     c_name[c], addr_at_done, 8'((int'(c_base[c]) + n_bytes) % FULL));
         end
         if (c_mode[c] == 0) begin
            n_cmp++;
            if (done_cyc !== exp_data.size() + 1) begin
               n_fail++;
               $display("[TB] FAIL %s_rate: got done at %0d, expected %0d",
                        c_name[c], done_cyc, exp_data.size() + 1);
            end
         end
      end
   endtask

   // A start raised in the done cycle must be accepted and stream normally,
   // and done must stay a single-cycle pulse.
   task automatic test_back_to_back();
      for (int i = 0; i < FULL; i++) mem[i] = 8'(i);
      drive_transfer(8'h30, 8'd2, 0);
      n_cmp++;
      if (done_cnt !== 1 || timed_out) begin
         n_fail++;
         $display("[TB] FAIL b2b_first_done: got %0d pulses, expected 1", done_cnt);
      end
      build_expected(8'h80, 8'd3);
      drive_transfer(8'h80, 8'd3, 0);
      n_cmp++;
      if (busy_at_start !== 1'b1 || addr_at_start !== 8'h80 || first_valid_cyc !== 1) begin
         n_fail++;
         $display("[TB] FAIL b2b_accept: got busy %b addr %0h first %0d, expected 1 80 1",
                  busy_at_start, addr_at_start, first_valid_cyc);
      end
      n_cmp++;
      if (got_data !== exp_data || got_last !== exp_last) begin
         n_fail++;
         $display("[TB] FAIL b2b_beats: got %p, expected %p", got_data, exp_data);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL b2b_pulse: got done %b busy %b, expected 0 0", done, busy);
      end
   endtask

   // Start while busy is ignored; reset mid-transfer aborts without done.
   task automatic test_abort();
      int spurious;
      for (int i = 0; i < FULL; i++) mem[i] = 8'(i);
      start = 1'b1; base_addr = 8'h40; len = 8'd8; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = 8'h90; len = 8'd2;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if (out_data !== 8'h41 || read_addr !== 8'h42 || busy !== 1'b1 || out_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL abort_ignore_start: got data %0h addr %0h busy %b, expected 41 42 1",
                  out_data, read_addr, busy);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++;
      if ({out_valid, busy, done, out_last} !== 4'b0000 || read_addr !== 8'h00 || out_data !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL abort_reset: got flags %b addr %0h data %0h, expected 0000 0 0",
                  {out_valid, busy, done, out_last}, read_addr, out_data);
      end
      spurious = 0;
      repeat (5) begin
         if (done || out_valid) spurious++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (spurious !== 0) begin
         n_fail++;
         $display("[TB] FAIL abort_no_done: got %0d active cycles, expected 0", spurious);
      end
      build_expected(8'h50, 8'd5);
      drive_transfer(8'h50, 8'd5, 0);
      n_cmp++;
      if (got_data !== exp_data || got_last !== exp_last || done_cnt !== 1) begin
         n_fail++;
         $display("[TB] FAIL abort_restart: got %p done %0d, expected %p done 1", got_data, done_cnt, exp_data);
      end
   endtask

   // Random memory contents, ranges and back-pressure.
   task automatic test_random();
      logic [7:0] b, l;
      for (int i = 0; i < FULL; i++) mem[i] = 8'($urandom);
      for (int t = 0; t < 8; t++) begin
         b = 8'($urandom);
         l = 8'($urandom_range(1, 40));
         build_expected(b, l);
         drive_transfer(b, l, 1);
         n_cmp++;
         if (got_data !== exp_data || got_last !== exp_last) begin
            n_fail++;
            $display("[TB] FAIL random%0d_beats: got %p, expected %p", t, got_data, exp_data);
         end
         n_cmp++;
         if (timed_out || done_cnt !== 1 || done_cyc !== last_hs_cyc + 1 || stab_viol !== 0) begin
            n_fail++;
            $display("[TB] FAIL random%0d_ctrl: got done %0d at %0d stalls %0d, expected 1 at %0d stalls 0",
                     t, done_cnt, done_cyc, stab_viol, last_hs_cyc + 1);
         end
         n_cmp++;
         if (addr_at_done !== 8'(b + l)) begin
            n_fail++;
            $display("[TB] FAIL random%0d_end_addr: got %0h, expected %0h", t, addr_at_done, 8'(b + l));
         end
      end
   endtask

   // Test sequence and summary.
   initial begin
      test_reset();
      test_stream_cases();
      test_back_to_back();
      test_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_stream_reader.md
# dmem_stream_reader

Sequential reader for the 256×8 data memory. It sweeps a programmed address range through the memory's combinational read port and emits each byte on a valid/ready byte stream, with the final beat flagged. It sits beside the memory, opposite the core's write path. It gives testbenches, debug dumps and later DMA logic a cycle-accurate way to drain memory contents without touching the write port.

## Interface
- ADDR_W, 8, memory address width (memory depth = 2^ADDR_W)
- DATA_W, 8, memory and stream data width
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first address to read, sampled with start
- len  in  ADDR_W  byte count, sampled with start; 0 encodes 2^ADDR_W (256)
- busy  out  1  high from the cycle after an accepted start until the final beat handshakes
- done  out  1  one-cycle pulse in the cycle after the final beat handshakes
- read_addr  out  ADDR_W  registered address driven to the memory read port
- read_data  in  DATA_W  memory read data, combinational from read_addr
- out_data  out  DATA_W  stream byte
- out_valid  out  1  stream beat valid
- out_ready  in  1  downstream accept
- out_last  out  1  marks the final beat of a transfer

## Operation
- Reset values: state IDLE; busy 0; done 0; out_valid 0; out_last 0; out_data 0; read_addr 0; remaining count 0.
- States: IDLE, STREAM, DRAIN, and CSUM (CSUM exists only under the macro).
- IDLE, start=1: latch read_addr←base_addr; remaining←len, with 0 meaning 256; go to STREAM; busy←1.
- STREAM: the output register is free when out_valid=0 or out_ready=1.
  - When free: out_data←read_data, out_valid←1, read_addr←read_addr+1, remaining−1.
  - Address arithmetic is modulo 2^ADDR_W. 0xFF wraps to 0x00 with no error.
  - The beat loaded when remaining=1 is the final data beat. Go to DRAIN, or to CSUM when the macro is defined.
- DRAIN: hold out_data and out_valid until out_ready. On that handshake: out_valid←0, busy←0, done pulses next cycle, go to IDLE.
- out_valid, once set, holds until handshake. out_data and out_last are stable while out_valid=1 and out_ready=0.
- start is ignored while busy. base_addr and len are don't-care outside the start cycle.
- rst mid-transfer aborts immediately. All outputs return to reset values the next cycle, and no done pulse is issued.
- The reader never writes memory. A concurrent write to the address currently on read_addr is captured with the memory's value at the capture edge.

## Timing
- Accepted start at edge N: read_addr=base_addr after N. First beat has out_valid=1 after edge N+1 with out_data=MEM[base_addr].
- Throughput: one beat per cycle while out_ready is held high.
- With out_ready tied high, a transfer of L bytes spans edges N+1..N+L. out_last is high on beat L; busy falls after edge N+L+1 and done is high in that same cycle.
- Back-pressure stalls read_addr. No bytes are skipped or duplicated.
- A start is accepted no earlier than the cycle done is high, because the state is already IDLE then.

## Configuration
- DMEM_STREAM_CHECKSUM_EN defined:
  - An 8-bit running sum (mod 256) accumulates each data byte as it loads.
  - After the last data beat handshakes, CSUM emits one extra beat: out_data = sum, out_last=1.
  - out_last is 0 on all data beats. Transfer length is L+1 beats.
  - The sum clears on start and on rst.
- Not defined: no CSUM state and no accumulator. out_last is on the final data beat.

## Structure
- Shared package dmem_pkg: ADDR_W and DATA_W defaults, the state enum (IDLE, STREAM, DRAIN, CSUM), and the len-zero-means-full-depth constant.
- One sub-module, dmem_out_stage: the out_data/out_valid/out_last holding register with load/consume logic.
- The FSM, address counter, remaining counter and checksum stay in the top module.

## Test plan
- Memory preloaded with MEM[i]=i. start with base=0x10, len=4, out_ready=1 → beats 0x10..0x13, out_last on 0x13, done one cycle later.
- base=0xFE, len=3 → beats 0xFE, 0xFF, 0x00; read_addr wraps to 0x01 at the end.
- len=0, base=0x00 → exactly 256 beats 0x00..0xFF, with out_last only on 0xFF.
- base=0x20, len=4, out_ready toggling 1,0,0,1,… → bytes 0x20..0x23 in order, each held stable while stalled, none duplicated.
- start repeated while busy, plus rst asserted after 2 beats → second start ignored; after rst, out_valid=0, busy=0, no done; a fresh start streams normally.
- With DMEM_STREAM_CHECKSUM_EN, base=0x01, len=3 → beats 0x01, 0x02, 0x03, then 0x06 with out_last; without the macro, out_last is on 0x03.
